inst_fetch_unit: RTL

- Fetch stage of the RISC-V core, directly upstream of decode and immediate generation.
- Holds the program counter and issues one instruction-memory request at a time over a req/rvalid interface with variable latency of at least 1 cycle.
- Presents the fetched instruction word, its PC and PC+4 to decode with a valid/ready handshake.
- Accepts branch and jump redirects from execute, and discards stale responses that are still in flight when a redirect arrives.

---
 rtl/inst_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - RISC-V fetch stage: PC, single-outstanding imem request, decode handshake
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        mis_q, mis_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    mis_d      = redirect_valid & (|redirect_pc[1:0]);

    if (redirect_valid) begin
      // A request issued in REQ, or still pending in WAIT/DRAIN, must be drained.
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      unique case (state_q)
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ:   state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            inst_d     = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + 32'd4;
            valid_d    = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_out_q   <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_req   = (state_q == S_REQ) & ~rst;
  assign imem_addr  = {pc_q[31:2], 2'b00};
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign pc_out     = pc_out_q;
  assign pc_plus4   = pc_plus4_q;
  assign misaligned = mis_q;

endmodule
